comparator_seq_ctrl: RTL and testbench
======================================

Name: comparator_seq_ctrl

Overview:
Sequencer that compares two WIDTH-bit unsigned operands with one shared 2-bit compare slice, one 2-bit digit pair per cycle, MSB pair first. It uses a start/busy/done handshake and holds the gt/lt/eq result until the next accepted start. It sits above the 2-bit comparator datapath and turns it into a multi-cycle N-bit magnitude comparator.

Parameters:
WIDTH, 8, operand width in bits; even, >= 2.
STEPS, WIDTH/2, derived localparam; number of 2-bit digit pairs.
CW, $clog2(STEPS)+1, derived localparam; width of the cycles output.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a compare; accepted only in IDLE.
a  input  WIDTH  operand A; sampled on the accepting edge.
b  input  WIDTH  operand B; sampled on the accepting edge.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; gt/lt/eq/cycles are valid from this cycle on.
gt  output  1  A > B.
lt  output  1  A < B.
eq  output  1  A == B.
cycles  output  CW  number of RUN cycles the last compare used (1..STEPS).

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy, done, gt, lt, eq = 0. cycles = 0. Operand registers and idx = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at an edge: latch a and b, set idx=STEPS-1, clear gt/lt/eq/cycles, go to RUN.
  - Otherwise hold the previous results.
- RUN, each cycle:
  - The slice compares a_q[2*idx+1:2*idx] against b_q[2*idx+1:2*idx]; cycles increments by 1 at the edge.
  - Pair unequal: latch gt/lt from the slice, go to DONE (early exit).
  - Pair equal and idx==0: set eq=1, go to DONE.
  - Otherwise: idx decrements, stay in RUN.
- DONE: done=1 for exactly this one cycle, then go to IDLE. Results stay stable until the next accepted start.
- Latency: done is high in the cycle after the Nth edge following the start-sampling edge, where N = cycles.
  - Best case N = 1.
  - Worst case, and always on equality, N = STEPS.
- Exactly one of gt/lt/eq is 1 after any completed compare. All three are 0 only after reset and before the first done, or while a compare is in progress.
- start while busy (RUN or DONE) is ignored; no queueing. Operand changes while busy have no effect.
- start in the cycle after DONE (IDLE) is accepted. The minimum start-to-start spacing is N+2 cycles.
- Reset mid-RUN or mid-DONE aborts immediately: all outputs go to 0, no done pulse, and the aborted compare is lost.
- idx never wraps. RUN exits at idx==0 in every case.

Optional Feature:
- Macro: CMP_SEQ_EARLY_EXIT_EN.
- Defined: early exit as above; latency depends on the data.
- Undefined: RUN always runs all STEPS pairs.
  - The first unequal pair, scanning MSB first, is latched into gt/lt. Later pairs do not overwrite it, tracked by an internal decided flag.
  - cycles = STEPS always, giving constant latency.
- Result values are identical in both builds.

Decomposition:
- Package cmp_seq_pkg:
  - state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Result-code constants: RES_NONE, RES_GT, RES_LT, RES_EQ, used internally as a 2-bit code decoded to gt/lt/eq.
- Sub-module cmp2_slice:
  - Purely combinational 2-bit compare.
  - Inputs: x[1:0], y[1:0]. Outputs: gt, lt, eq.
  - Instantiated once, with its inputs selected by idx.

Test Plan:
All scenarios use WIDTH=8.
- a=8'hA5, b=8'hA5, start -> 4 RUN cycles; done high on the 5th cycle after start is sampled; eq=1, gt=lt=0, cycles=4.
- a=8'hC0, b=8'h40 -> top pair 11 vs 01 gives gt=1, lt=eq=0. With EN: cycles=1, done 2 cycles after start. Without EN: cycles=4, gt=1.
- a=8'h12, b=8'h13 -> lt=1 at the last pair, cycles=4 in both builds.
- Start a=8'h01, b=8'h00, then pulse start with a=8'h00, b=8'hFF during RUN -> second start ignored; result gt=1; busy drops after the single done pulse.
- Drive rst_n low mid-RUN of an 8'h12 vs 8'h13 compare -> busy, done, gt, lt, eq, cycles = 0 immediately without a clock. After release, start a=8'hFF, b=8'h00 -> gt=1, cycles=1 (EN build).
- start held high continuously with varying operands -> a new compare is accepted only in the IDLE cycle after each done. Exactly one done pulse per accepted compare; results match the operands sampled at each acceptance.

Source files
------------

// File: rtl/cmp_seq_pkg.sv
// Shared types and result codes for the sequential magnitude comparator.
package cmp_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] RES_NONE = 2'd0;
   localparam logic [1:0] RES_GT   = 2'd1;
   localparam logic [1:0] RES_LT   = 2'd2;
   localparam logic [1:0] RES_EQ   = 2'd3;

   // Encode the slice flags as a result code; an equal pair maps to RES_EQ.
   function automatic logic [1:0] slice_res(input logic gt, input logic lt);
      logic [1:0] code;
      if (gt) begin
         code = RES_GT;
      end else if (lt) begin
         code = RES_LT;
      end else begin
         code = RES_EQ;
      end
      return code;
   endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Purely combinational 2-bit unsigned magnitude compare slice.
module cmp2_slice
   import cmp_seq_pkg::*;
(
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       gt,
   output logic       lt,
   output logic       eq
);

   assign gt = (x > y);
   assign lt = (x < y);
   assign eq = (x == y);

endmodule

// File: rtl/comparator_seq_ctrl.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning 2-bit pairs MSB first.
// Build option: CMP_SEQ_EARLY_EXIT_EN stops at the first unequal pair.
module comparator_seq_ctrl
   import cmp_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [WIDTH-1:0]                   a,
   input  logic [WIDTH-1:0]                   b,
   output logic                               busy,
   output logic                               done,
   output logic                               gt,
   output logic                               lt,
   output logic                               eq,
   output logic [$clog2(WIDTH/2):0]           cycles
);

   localparam int STEPS = WIDTH / 2;
   localparam int CW    = $clog2(STEPS) + 1;
   localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(STEPS - 1);
   localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
   localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CYC_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CYC_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] a_r, a_nxt_s;
   logic [WIDTH-1:0] b_r, b_nxt_s;
   logic [IW-1:0]    idx_r, idx_nxt_s;
   logic [1:0]       res_r, res_nxt_s;
   logic [CW-1:0]    cycles_r, cycles_nxt_s;
   logic             busy_r, done_r, gt_r, lt_r, eq_r;
   logic [1:0]       pair_a_s, pair_b_s;
   logic             pair_gt_s, pair_lt_s, pair_eq_s;
`ifndef CMP_SEQ_EARLY_EXIT_EN
   logic             decided_r, decided_nxt_s;
`endif

   assign pair_a_s = a_r[{idx_r, 1'b0} +: 2];
   assign pair_b_s = b_r[{idx_r, 1'b0} +: 2];

   cmp2_slice u_slice (
      .x  (pair_a_s),
      .y  (pair_b_s),
      .gt (pair_gt_s),
      .lt (pair_lt_s),
      .eq (pair_eq_s)
   );

   // Next-state, operand, index and result selection for the scan FSM.
   always_comb begin
      state_nxt_s  = state_r;
      a_nxt_s      = a_r;
      b_nxt_s      = b_r;
      idx_nxt_s    = idx_r;
      res_nxt_s    = res_r;
      cycles_nxt_s = cycles_r;
`ifndef CMP_SEQ_EARLY_EXIT_EN
      decided_nxt_s = decided_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               a_nxt_s      = a;
               b_nxt_s      = b;
               idx_nxt_s    = IDX_LAST;
               res_nxt_s    = RES_NONE;
               cycles_nxt_s = CYC_ZERO;
`ifndef CMP_SEQ_EARLY_EXIT_EN
               decided_nxt_s = 1'b0;
`endif
               state_nxt_s  = RUN;
            end else begin
               state_nxt_s  = IDLE;
            end
         end
         RUN: begin
            cycles_nxt_s = cycles_r + CYC_ONE;
`ifdef CMP_SEQ_EARLY_EXIT_EN
            if (!pair_eq_s) begin
               res_nxt_s   = slice_res(pair_gt_s, pair_lt_s);
               state_nxt_s = DONE;
            end else if (idx_r == IDX_ZERO) begin
               res_nxt_s   = RES_EQ;
               state_nxt_s = DONE;
            end else begin
               idx_nxt_s   = idx_r - IDX_ONE;
               state_nxt_s = RUN;
            end
`else
            // The first unequal pair wins; later pairs only advance the scan.
            if (!decided_r && !pair_eq_s) begin
               res_nxt_s     = slice_res(pair_gt_s, pair_lt_s);
               decided_nxt_s = 1'b1;
            end else if (!decided_r && (idx_r == IDX_ZERO)) begin
               res_nxt_s     = RES_EQ;
            end else begin
               res_nxt_s     = res_r;
            end
            if (idx_r == IDX_ZERO) begin
               state_nxt_s = DONE;
            end else begin
               idx_nxt_s   = idx_r - IDX_ONE;
               state_nxt_s = RUN;
            end
`endif
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         idx_r    <= IDX_ZERO;
         res_r    <= RES_NONE;
         cycles_r <= CYC_ZERO;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         gt_r     <= 1'b0;
         lt_r     <= 1'b0;
         eq_r     <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         a_r      <= a_nxt_s;
         b_r      <= b_nxt_s;
         idx_r    <= idx_nxt_s;
         res_r    <= res_nxt_s;
         cycles_r <= cycles_nxt_s;
         busy_r   <= (state_nxt_s != IDLE);
         done_r   <= (state_nxt_s == DONE);
         gt_r     <= (res_nxt_s == RES_GT);
         lt_r     <= (res_nxt_s == RES_LT);
         eq_r     <= (res_nxt_s == RES_EQ);
      end
   end

`ifndef CMP_SEQ_EARLY_EXIT_EN
   // Marks that an unequal pair has already fixed gt/lt for this compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decided_r <= 1'b0;
      end else begin
         decided_r <= decided_nxt_s;
      end
   end
`endif

   assign busy   = busy_r;
   assign done   = done_r;
   assign gt     = gt_r;
   assign lt     = lt_r;
   assign eq     = eq_r;
   assign cycles = cycles_r;

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Directed, table-driven bench for comparator_seq_ctrl (WIDTH=8).
module tb_comparator_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, gt, lt, eq;
   logic [2:0] cycles;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       gt;
      logic       lt;
      logic       eq;
      int         cyc_en;
   } vec_t;

   vec_t vecs [8];

   comparator_seq_ctrl #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .gt     (gt),
      .lt     (lt),
      .eq     (eq),
      .cycles (cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic int exp_cycles(input vec_t v);
`ifdef CMP_SEQ_EARLY_EXIT_EN
      return v.cyc_en;
`else
      return 4;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for done; k = negedges counted from the accepting edge.
   task automatic wait_done(output int k, output logic busy_first);
      k = 0;
      busy_first = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) busy_first = busy;
         if (done) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic check_result(input vec_t v, input string tag, input int k, input logic bf);
      chk({tag, " busy_after_accept"}, {31'd0, bf}, 32'd1);
      chk({tag, " latency"}, k, exp_cycles(v) + 1);
      chk({tag, " gt_lt_eq"}, {29'd0, gt, lt, eq}, {29'd0, v.gt, v.lt, v.eq});
      chk({tag, " cycles"}, {29'd0, cycles}, exp_cycles(v));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   k;
      logic bf;
      @(negedge clk);
      a = v.a; b = v.b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~v.a; b = ~v.b;
      wait_done(k, bf);
      check_result(v, tag, k, bf);
      @(negedge clk);
      chk({tag, " idle_busy_done"}, {30'd0, busy, done}, 32'd0);
      chk({tag, " hold"}, {29'd0, gt, lt, eq}, {29'd0, v.gt, v.lt, v.eq});
   endtask

   initial begin
      int   k, dcount;
      logic bf;
      logic [2:0] seen;

      vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 4};
      vecs[1] = '{8'hC0, 8'h40, 1'b1, 1'b0, 1'b0, 1};
      vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 4};
      vecs[3] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 4};
      vecs[4] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1};
      vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[6] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
      vecs[7] = '{8'h34, 8'h38, 1'b0, 1'b1, 1'b0, 3};

      rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
      #12;
      chk("reset_outputs", {24'd0, busy, done, gt, lt, eq, cycles}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {24'd0, busy, done, gt, lt, eq, cycles}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // start while busy must be ignored
      @(negedge clk);
      a = 8'h01; b = 8'h00; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      a = 8'h00; b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcount = 0;
      seen = 3'b000;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done) begin
            dcount++;
            seen = {gt, lt, eq};
         end
      end
      chk("busy_start_done_count", dcount, 32'd1);
      chk("busy_start_result", {29'd0, seen}, 32'b100);
      chk("busy_start_busy_low", {31'd0, busy}, 32'd0);

      // reset in the middle of RUN
      @(negedge clk);
      a = 8'h12; b = 8'h13; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", {24'd0, busy, done, gt, lt, eq, cycles}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[4], "post_reset");

      // start held high: re-accept in the IDLE cycle after each done
      @(negedge clk);
      a = vecs[1].a; b = vecs[1].b; start = 1'b1;
      for (int j = 0; j < 3; j++) begin
         vec_t v;
         v = (j == 0) ? vecs[1] : ((j == 1) ? vecs[2] : vecs[7]);
         @(posedge clk);
         #1;
         a = ~v.a; b = ~v.b;
         wait_done(k, bf);
         check_result(v, $sformatf("held%0d", j), k, bf);
         if (j == 0) begin
            a = vecs[2].a; b = vecs[2].b;
         end else begin
            a = vecs[7].a; b = vecs[7].b;
         end
         if (j == 2) start = 1'b0;
         @(negedge clk);
         chk($sformatf("held%0d_idle_gap", j), {30'd0, busy, done}, 32'd0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
